// File: rtl/channel_pkg.sv
// Shared definitions for the channel send/receive engines.
// State encoding, channel word layout and the pid-to-set helper.
package channel_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_REQ,
    S_READ_CAP,
    S_WRITE_MSG,
    S_WRITE_CHAN,
    S_DONE
  } chan_state_t;

  localparam int PID_OFFSET = 0;
  localparam int MSG_OFFSET = 1;
  localparam int NULL_PID   = 0;

  localparam logic RAM_READ  = 1'b0;
  localparam logic RAM_WRITE = 1'b1;

  // Bit idx of the set mask for pid; pids above proc_count select nothing.
  function automatic logic pid_selects(
    input int unsigned pid,
    input int unsigned idx,
    input int unsigned proc_count
  );
    return (pid <= proc_count) && (pid == idx);
  endfunction

endpackage

// File: rtl/alt_set_classifier.sv
// Classifies a receiver pid against the alternation sets.
// Purely combinational; shared with the receive engine.
module alt_set_classifier
  import channel_pkg::*;
#(
  parameter int PID_BITS   = 8,
  parameter int PROC_COUNT = 16
) (
  input  logic [PID_BITS-1:0] rxPid,
  input  logic [PROC_COUNT:0] altSet,
  input  logic [PROC_COUNT:0] altReadySet,
  output logic                isNull,
  output logic                inAlt,
  output logic                inReady
);

  logic [PROC_COUNT:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i <= PROC_COUNT; i++) begin
      mask[i] = pid_selects(32'(rxPid), i, PROC_COUNT);
    end
  end

  assign isNull  = (rxPid == PID_BITS'(NULL_PID));
  assign inAlt   = |(altSet & mask);
  assign inReady = |(altReadySet & mask);

endmodule

// File: rtl/channel_send_burst.sv
// Rendezvous send of MSG_WORDS words on a memory-resident channel,
// with receiver classification reported to the scheduler.
module channel_send_burst
  import channel_pkg::*;
#(
  parameter int ADDR_BITS  = 16,
  parameter int DATA_BITS  = 16,
  parameter int PID_BITS   = 8,
  parameter int PROC_COUNT = 16,
  parameter int MSG_WORDS  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  input  logic [ADDR_BITS-1:0]           channel,
  input  logic [MSG_WORDS*DATA_BITS-1:0] message,
  input  logic [PID_BITS-1:0]            txPid,
  input  logic [PROC_COUNT:0]            altSet,
  input  logic [PROC_COUNT:0]            altReadySet,
  output logic [ADDR_BITS-1:0]           address,
  output logic                           readWriteMode,
  output logic [DATA_BITS-1:0]           dataIn,
  input  logic [DATA_BITS-1:0]           dataOut,
  output logic [PID_BITS-1:0]            rxPid,
  output logic                           scheduleReceiver,
  output logic                           descheduleSender,
  output logic                           addToAltReadySet,
  output logic [MSG_WORDS*DATA_BITS-1:0] deliveredMessage
);

  localparam int CW = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(MSG_WORDS - 1);

  chan_state_t          state;
  logic [CW-1:0]        cnt;
  logic [ADDR_BITS-1:0] chan_q;
  logic [PID_BITS-1:0]  tx_q;
  logic [PID_BITS-1:0]  chan_word;

  logic is_null;
  logic in_alt;
  logic in_ready;

  logic                nxt_sched;
  logic                nxt_desch;
  logic                nxt_add;
  logic [PID_BITS-1:0] nxt_word;

  generate
    if (DATA_BITS > PID_BITS) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^dataOut[DATA_BITS-1:PID_BITS];
    end
  endgenerate

  alt_set_classifier #(
    .PID_BITS  (PID_BITS),
    .PROC_COUNT(PROC_COUNT)
  ) u_cls (
    .rxPid      (rxPid),
    .altSet     (altSet),
    .altReadySet(altReadySet),
    .isNull     (is_null),
    .inAlt      (in_alt),
    .inReady    (in_ready)
  );

  // Null pid takes precedence even if bit 0 of altSet happens to be set.
  always_comb begin
    nxt_sched = 1'b0;
    nxt_desch = 1'b0;
    nxt_add   = 1'b0;
    nxt_word  = tx_q;
    unique case (1'b1)
      is_null: begin
        nxt_desch = 1'b1;
      end
      (!is_null && in_alt && !in_ready): begin
        nxt_add   = 1'b1;
        nxt_sched = 1'b1;
        nxt_desch = 1'b1;
      end
      (!is_null && in_alt && in_ready): begin
        nxt_desch = 1'b1;
      end
      default: begin
        nxt_sched = 1'b1;
        nxt_word  = '0;
      end
    endcase
  end

  always_comb begin
    address       = '0;
    dataIn        = '0;
    readWriteMode = RAM_READ;
    unique case (state)
      S_READ_REQ, S_READ_CAP: begin
        address = chan_q + ADDR_BITS'(PID_OFFSET);
      end
      S_WRITE_MSG: begin
        address       = chan_q + ADDR_BITS'(MSG_OFFSET)
                      + ADDR_BITS'(cnt);
        dataIn        = deliveredMessage[int'(cnt)*DATA_BITS +: DATA_BITS];
        readWriteMode = RAM_WRITE;
      end
      S_WRITE_CHAN: begin
        address       = chan_q + ADDR_BITS'(PID_OFFSET);
        dataIn        = DATA_BITS'(chan_word);
        readWriteMode = RAM_WRITE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      cnt              <= '0;
      chan_q           <= '0;
      tx_q             <= '0;
      chan_word        <= '0;
      rxPid            <= '0;
      scheduleReceiver <= 1'b0;
      descheduleSender <= 1'b0;
      addToAltReadySet <= 1'b0;
      deliveredMessage <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            chan_q           <= channel;
            tx_q             <= txPid;
            deliveredMessage <= message;
            scheduleReceiver <= 1'b0;
            descheduleSender <= 1'b0;
            addToAltReadySet <= 1'b0;
            cnt              <= '0;
            busy             <= 1'b1;
            state            <= S_READ_REQ;
          end
        end
        S_READ_REQ: state <= S_READ_CAP;
        S_READ_CAP: begin
          rxPid <= dataOut[PID_BITS-1:0];
          state <= S_WRITE_MSG;
        end
        S_WRITE_MSG: begin
          if (cnt == '0) begin
            scheduleReceiver <= nxt_sched;
            descheduleSender <= nxt_desch;
            addToAltReadySet <= nxt_add;
            chan_word        <= nxt_word;
          end
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= S_WRITE_CHAN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WRITE_CHAN: begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/channel_send_burst.md
Name: channel_send_burst

Overview:
- Parametrised successor to the single-word channel send engine.
- Performs a rendezvous send of MSG_WORDS data words on a memory-resident channel, classifies the waiting receiver (none / alternation / ordinary) and reports scheduling actions to the scheduler.
- Re-triggerable via a start/busy/done handshake, so no reset is needed between sends.
- Sits between the core's channel-instruction decoder and the shared RAM port.

Parameters:
- ADDR_BITS, 16, RAM address width.
- DATA_BITS, 16, RAM word width.
- PID_BITS, 8, process id width (PID_BITS <= DATA_BITS); pid 0 means "no process".
- PROC_COUNT, 16, highest pid; alternation sets are PROC_COUNT+1 bits wide.
- MSG_WORDS, 2, message length in words (>= 1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin send; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until the DONE cycle inclusive
- done  out  1  one-cycle pulse when the send is complete
- channel  in  ADDR_BITS  channel base address (word 0 = waiting pid, words 1..MSG_WORDS = message)
- message  in  MSG_WORDS*DATA_BITS  message; word k occupies bits [k*DATA_BITS +: DATA_BITS]
- txPid  in  PID_BITS  sender pid
- altSet  in  PROC_COUNT+1  processes currently in an alternation
- altReadySet  in  PROC_COUNT+1  alternating processes that are already readied
- address  out  ADDR_BITS  RAM address
- readWriteMode  out  1  RAM_READ / RAM_WRITE (codebase macros)
- dataIn  out  DATA_BITS  RAM write data
- dataOut  in  DATA_BITS  RAM read data, valid one cycle after the read address is presented
- rxPid  out  PID_BITS  receiver pid read from the channel
- scheduleReceiver  out  1  result flag
- descheduleSender  out  1  result flag
- addToAltReadySet  out  1  result flag
- deliveredMessage  out  MSG_WORDS*DATA_BITS  copy of the message as latched at start

Behaviour:
- Reset (reset==0 at a clk edge):
  - state goes to IDLE.
  - busy, done, scheduleReceiver, descheduleSender, addToAltReadySet, rxPid, deliveredMessage and the word counter all go to 0.
  - Reset mid-operation abandons the send with no done pulse; RAM writes already issued stand.
- States: IDLE -> READ_REQ -> READ_CAP -> WRITE_MSG (MSG_WORDS cycles) -> WRITE_CHAN -> DONE -> IDLE.
- IDLE:
  - address/dataIn are don't-care; mode is READ.
  - On start: latch channel, txPid and message (message is also copied to deliveredMessage), clear the three result flags, go to READ_REQ.
- READ_REQ: address=channel, READ.
- READ_CAP: address=channel, READ; rxPid <= dataOut[PID_BITS-1:0].
- Classification is evaluated combinationally from the registered rxPid and registered in the first WRITE_MSG cycle. With f = 1<<rxPid (0 when rxPid > PROC_COUNT), inAlt = |(altSet&f) and inReady = |(altReadySet&f):
  - rxPid==0: descheduleSender=1; chanWord=txPid.
  - inAlt & ~inReady: addToAltReadySet=1, scheduleReceiver=1, descheduleSender=1; chanWord=txPid.
  - inAlt & inReady: descheduleSender=1; chanWord=txPid.
  - otherwise: scheduleReceiver=1; chanWord=0.
- WRITE_MSG, cycle k (0..MSG_WORDS-1): address=channel+1+k, computed modulo 2^ADDR_BITS; dataIn = message word k; WRITE.
- WRITE_CHAN: address=channel; dataIn = zero-extended chanWord; WRITE.
- DONE: done=1, busy=1, RAM READ; go to IDLE.
- Latency: start accepted at edge 0 -> done high in cycle MSG_WORDS+4.
- Result outputs and rxPid hold from DONE until the next accepted start.
- start while busy is ignored. start in the DONE cycle is ignored; start is accepted again in the following IDLE cycle.
- Exactly MSG_WORDS+1 RAM writes per send; no other cycle drives WRITE.

Decomposition:
- Shared package (channel_pkg):
  - state encoding;
  - channel word offsets (PID_OFFSET=0, MSG_OFFSET=1);
  - NULL_PID=0;
  - a pid-to-set-mask function with range guard.
- One sub-module, alt_set_classifier: combinational; rxPid, altSet, altReadySet -> {isNull, inAlt, inReady}. It is reused by the future receive engine.

Test Plan:
- No receiver: RAM[0x40]=0, channel=0x40, msg={0xBEEF,0x1234}, txPid=3 -> RAM[0x41]=0x1234, RAM[0x42]=0xBEEF, RAM[0x40]=3; descheduleSender=1, scheduleReceiver=0; done in cycle 6.
- Ordinary receiver: RAM[0x40]=5, altSet=0 -> RAM[0x40]=0, scheduleReceiver=1, descheduleSender=0, rxPid=5.
- Alternation first arm: RAM[0x40]=7, altSet bit7=1, altReadySet=0 -> addToAltReadySet=1, scheduleReceiver=1, descheduleSender=1, RAM[0x40]=txPid.
- Alternation already readied: altSet and altReadySet bit7 both 1 -> scheduleReceiver=0, addToAltReadySet=0, descheduleSender=1, RAM[0x40]=txPid.
- Wrap and out-of-range pid: channel=0xFFFF, RAM[0xFFFF]=200 (> PROC_COUNT) -> writes to 0x0000 and 0x0001; treated as an ordinary receiver.
- Handshake: start held high through a whole send, then reset pulsed in the WRITE_MSG cycle -> exactly one send per IDLE acceptance; after reset all outputs are 0 and no done pulse occurs.
